// File: rtl/spi_flash_xip_pkg.sv
// Shared definitions for the SPI flash execute-in-place bridge: FSM encoding,
// CSR offsets, the READ opcode and the SPI frame length helper.
package spi_flash_xip_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CS_SETUP = 2'd1,
      ST_SHIFT    = 2'd2,
      ST_CS_HOLD  = 2'd3
   } state_t;

   localparam logic [4:0] CSR_DIV_OFS    = 5'h00;
   localparam logic [4:0] CSR_CS_SEL_OFS = 5'h04;
   localparam logic [4:0] CSR_STATUS_OFS = 5'h08;

   localparam logic [7:0] OPCODE_READ = 8'h03;
   localparam int         DATA_BITS   = 32;

   // Frame length: opcode byte, address bytes, one data word.
   function automatic int nbits(input int addr_bytes);
      return 8 + 8 * addr_bytes + DATA_BITS;
   endfunction

   // Flash bytes arrive lowest address first; APB word is little-endian.
   function automatic logic [31:0] byte_swap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/spi_flash_xip_shifter.sv
// Mode-0 SPI shift engine: divider, sclk generation, bit counter and TX/RX
// shift registers with a start/done handshake.
module spi_flash_xip_shifter
   import spi_flash_xip_pkg::*;
#(
   parameter int NBITS = 64,
   parameter int DIV_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [DIV_W-1:0]     div,
   input  logic [NBITS-1:0]     tx_data,
   input  logic                 miso,
   output logic                 sclk,
   output logic                 mosi,
   output logic                 done,
   output logic [DATA_BITS-1:0] rx_data
);

   localparam int              CNT_W    = $clog2(NBITS);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

   logic                 active_r;
   logic                 sclk_r;
   logic                 mosi_r;
   logic [DIV_W-1:0]     div_r;
   logic [DIV_W-1:0]     div_cnt_r;
   logic [CNT_W-1:0]     bit_cnt_r;
   logic [NBITS-1:0]     tx_r;
   logic [DATA_BITS-1:0] rx_r;
   logic                 half_end_s;

   assign half_end_s = active_r && (div_cnt_r == div_r);
   // Frame ends on the falling edge of the last bit.
   assign done    = half_end_s && sclk_r && (bit_cnt_r == LAST_BIT);
   assign sclk    = sclk_r;
   assign mosi    = mosi_r;
   assign rx_data = rx_r;

   // Shift engine state: half-period counting, edge generation, data movement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_r  <= 1'b0;
         sclk_r    <= 1'b0;
         mosi_r    <= 1'b0;
         div_r     <= {DIV_W{1'b0}};
         div_cnt_r <= {DIV_W{1'b0}};
         bit_cnt_r <= {CNT_W{1'b0}};
         tx_r      <= {NBITS{1'b0}};
         rx_r      <= {DATA_BITS{1'b0}};
      end else if (start && !active_r) begin
         active_r  <= 1'b1;
         sclk_r    <= 1'b0;
         mosi_r    <= tx_data[NBITS-1];
         tx_r      <= {tx_data[NBITS-2:0], 1'b0};
         div_r     <= div;
         div_cnt_r <= {DIV_W{1'b0}};
         bit_cnt_r <= {CNT_W{1'b0}};
      end else if (active_r) begin
         if (half_end_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            if (!sclk_r) begin
               sclk_r <= 1'b1;
               rx_r   <= {rx_r[DATA_BITS-2:0], miso};
            end else begin
               sclk_r <= 1'b0;
               if (bit_cnt_r == LAST_BIT) begin
                  active_r <= 1'b0;
                  mosi_r   <= 1'b0;
               end else begin
                  bit_cnt_r <= bit_cnt_r + CNT_W'(1'b1);
                  mosi_r    <= tx_r[NBITS-1];
                  tx_r      <= {tx_r[NBITS-2:0], 1'b0};
               end
            end
         end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
         end
      end else begin
         sclk_r <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_flash_xip.sv
// APB slave SPI flash execute-in-place bridge with a small CSR window.
// Optional one-word read buffer enabled by SPI_FLASH_XIP_LINEBUF_EN.
module spi_flash_xip
   import spi_flash_xip_pkg::*;
#(
   parameter logic [31:0] FLASH_ADDR_START = 32'h3000_0000,
   parameter logic [31:0] FLASH_ADDR_END   = 32'h3fff_ffff,
   parameter int          CS_NUM           = 2,
   parameter int          ADDR_BYTES       = 3,
   parameter int          DIV_W            = 8,
   parameter int          DEFAULT_DIV      = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       in_paddr,
   input  logic              in_psel,
   input  logic              in_penable,
   input  logic [2:0]        in_pprot,
   input  logic              in_pwrite,
   input  logic [31:0]       in_pwdata,
   input  logic [3:0]        in_pstrb,
   output logic              in_pready,
   output logic [31:0]       in_prdata,
   output logic              in_pslverr,
   output logic              spi_clk,
   output logic [CS_NUM-1:0] spi_cs,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int NBITS = nbits(ADDR_BYTES);
   localparam int CSW   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1;
   localparam int AW    = 8 * ADDR_BYTES;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [DIV_W-1:0]  div_r;
   logic [CSW-1:0]    cs_sel_r;
   logic [CS_NUM-1:0] spi_cs_r;
   logic [31:0]       addr_r;
   logic              abort_r;
   logic              pready_r;
   logic [31:0]       prdata_r;
   logic              pslverr_r;

   logic              access_s;
   logic              in_window_s;
   logic              flash_rd_s;
   logic              req_s;
   logic              spi_req_s;
   logic              quick_s;
   logic              csr_wr_s;
   logic              cs_sel_bad_s;
   logic              busy_s;
   logic              lb_hit_s;
   logic [31:0]       lb_data_s;
   logic [31:0]       quick_rdata_s;
   logic              quick_err_s;
   logic [CS_NUM-1:0] cs_onehot_s;
   logic              shift_start_s;
   logic              shift_done_s;
   logic [NBITS-1:0]  tx_data_s;
   logic [31:0]       rx_data_s;
   logic              unused_s;

   assign access_s     = in_psel && in_penable;
   assign in_window_s  = (in_paddr >= FLASH_ADDR_START) && (in_paddr <= FLASH_ADDR_END);
   assign flash_rd_s   = in_window_s && !in_pwrite;
   // Requests are only taken while idle and not already being answered.
   assign req_s        = (state_r == ST_IDLE) && in_psel && !pready_r;
   assign spi_req_s    = req_s && in_penable && flash_rd_s && !lb_hit_s;
   assign quick_s      = req_s && !(flash_rd_s && !lb_hit_s);
   assign csr_wr_s     = quick_s && !in_window_s && in_pwrite;
   assign cs_sel_bad_s = (in_pwdata >= 32'(CS_NUM));
   assign busy_s       = (state_r != ST_IDLE);
   assign shift_start_s = (state_r == ST_CS_SETUP);
   assign tx_data_s    = {OPCODE_READ, addr_r[AW-1:0], 32'h0000_0000};
   assign unused_s     = ^{in_pprot, in_pstrb, addr_r};

   assign in_pready  = pready_r;
   assign in_prdata  = prdata_r;
   assign in_pslverr = pslverr_r;
   assign spi_cs     = spi_cs_r;

`ifdef SPI_FLASH_XIP_LINEBUF_EN
   logic        lb_valid_r;
   logic [29:0] lb_addr_r;
   logic [31:0] lb_data_r;

   assign lb_hit_s  = flash_rd_s && lb_valid_r && (lb_addr_r == in_paddr[31:2]);
   assign lb_data_s = lb_data_r;

   // Line buffer: refilled by every finished SPI read, dropped on CSR writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lb_valid_r <= 1'b0;
         lb_addr_r  <= 30'h0;
         lb_data_r  <= 32'h0;
      end else if (csr_wr_s) begin
         lb_valid_r <= 1'b0;
      end else if (shift_done_s) begin
         lb_valid_r <= 1'b1;
         lb_addr_r  <= addr_r[31:2];
         lb_data_r  <= byte_swap(rx_data_s);
      end else begin
         lb_valid_r <= lb_valid_r;
      end
   end
`else
   assign lb_hit_s  = 1'b0;
   assign lb_data_s = 32'h0;
`endif

   // One-hot of the selected chip select.
   always_comb begin
      for (int i = 0; i < CS_NUM; i++) begin
         cs_onehot_s[i] = (cs_sel_r == CSW'(i));
      end
   end

   // Response for accesses answered without SPI traffic.
   always_comb begin
      quick_rdata_s = 32'h0;
      quick_err_s   = 1'b0;
      if (in_window_s) begin
         if (in_pwrite) begin
            quick_err_s = 1'b1;
         end else begin
            quick_rdata_s = lb_data_s;
         end
      end else begin
         case (in_paddr[4:0])
            CSR_DIV_OFS:    quick_rdata_s = in_pwrite ? 32'h0 : 32'(div_r);
            CSR_CS_SEL_OFS: begin
               if (in_pwrite) begin
                  quick_err_s = cs_sel_bad_s;
               end else begin
                  quick_rdata_s = 32'(cs_sel_r);
               end
            end
            CSR_STATUS_OFS: quick_rdata_s = in_pwrite ? 32'h0 : {31'h0, busy_s};
            default:        quick_rdata_s = 32'h0;
         endcase
      end
   end

   // FSM next state.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (spi_req_s) begin
               state_nxt_s = ST_CS_SETUP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CS_SETUP: state_nxt_s = ST_SHIFT;
         ST_SHIFT: begin
            if (shift_done_s) begin
               state_nxt_s = ST_CS_HOLD;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         ST_CS_HOLD: state_nxt_s = ST_IDLE;
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Transfer context: address, chip select, and abandoned-transfer tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_r   <= 32'h0;
         abort_r  <= 1'b0;
         spi_cs_r <= {CS_NUM{1'b1}};
      end else if (spi_req_s) begin
         addr_r   <= {in_paddr[31:2], 2'b00};
         abort_r  <= 1'b0;
         spi_cs_r <= ~cs_onehot_s;
      end else begin
         if (shift_done_s) begin
            spi_cs_r <= {CS_NUM{1'b1}};
         end
         if (busy_s && !access_s) begin
            abort_r <= 1'b1;
         end
      end
   end

   // Control/status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_r    <= DIV_W'(DEFAULT_DIV);
         cs_sel_r <= {CSW{1'b0}};
      end else if (csr_wr_s) begin
         case (in_paddr[4:0])
            CSR_DIV_OFS: div_r <= in_pwdata[DIV_W-1:0];
            CSR_CS_SEL_OFS: begin
               if (!cs_sel_bad_s) begin
                  cs_sel_r <= in_pwdata[CSW-1:0];
               end
            end
            default: div_r <= div_r;
         endcase
      end
   end

   // APB response: single-cycle pready pulse, data zero outside the pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pready_r  <= 1'b0;
         prdata_r  <= 32'h0;
         pslverr_r <= 1'b0;
      end else if (quick_s) begin
         pready_r  <= 1'b1;
         prdata_r  <= quick_rdata_s;
         pslverr_r <= quick_err_s;
      end else if (shift_done_s && !abort_r && access_s) begin
         pready_r  <= 1'b1;
         prdata_r  <= byte_swap(rx_data_s);
         pslverr_r <= 1'b0;
      end else begin
         pready_r  <= 1'b0;
         prdata_r  <= 32'h0;
         pslverr_r <= 1'b0;
      end
   end

   spi_flash_xip_shifter #(
      .NBITS (NBITS),
      .DIV_W (DIV_W)
   ) u_shifter (
      .clk     (clk),
      .reset   (reset),
      .start   (shift_start_s),
      .div     (div_r),
      .tx_data (tx_data_s),
      .miso    (spi_miso),
      .sclk    (spi_clk),
      .mosi    (spi_mosi),
      .done    (shift_done_s),
      .rx_data (rx_data_s)
   );

endmodule

// File: doc/spi_flash_xip.md
Name: spi_flash_xip

Overview:
- Parametrised APB-slave SPI flash execute-in-place controller. Second-generation flash bridge.
- Drives the SPI pins directly with an internal shift engine; no separate SPI core and no APB master sequencing.
- APB reads in [FLASH_ADDR_START, FLASH_ADDR_END] become SPI READ transactions. All other addresses hit a small CSR window (divider, chip-select, status).
- Sits on the peripheral APB crossbar in place of the previous flash bridge.

Parameters:
- FLASH_ADDR_START, 32'h30000000, first byte address of the flash read window
- FLASH_ADDR_END, 32'h3fffffff, last byte address of the flash read window
- CS_NUM, 2, number of SPI chip-select outputs (1..8)
- ADDR_BYTES, 3, flash address bytes sent after opcode (3 or 4); 4 takes paddr[31:0]
- DIV_W, 8, width of clock divider register
- DEFAULT_DIV, 0, reset value of divider

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_paddr  in  32  APB address
- in_psel  in  1  APB select
- in_penable  in  1  APB enable
- in_pprot  in  3  APB protection (ignored)
- in_pwrite  in  1  APB write
- in_pwdata  in  32  APB write data
- in_pstrb  in  4  APB strobes (CSR writes: full-word only, strobes ignored)
- in_pready  out  1  APB ready
- in_prdata  out  32  APB read data
- in_pslverr  out  1  APB error
- spi_clk  out  1  SPI clock, mode 0 (idle low)
- spi_cs  out  CS_NUM  chip selects, active low
- spi_mosi  out  1  SPI data out
- spi_miso  in  1  SPI data in

Behaviour:
- Reset (async, active-high): spi_clk=0, spi_cs=all ones, spi_mosi=0, in_pready=0, in_prdata=0, in_pslverr=0, FSM=IDLE, DIV=DEFAULT_DIV, CS_SEL=0.
- CSR window (paddr not in flash window), offset paddr[4:0]:
  - 0x00 DIV: R/W, DIV_W bits.
  - 0x04 CS_SEL: R/W, clog2(CS_NUM) bits. A write value >= CS_NUM is ignored and returns pslverr=1.
  - 0x08 STATUS: RO, bit0=busy.
  - Other offsets: read 0, write ignored, pslverr=0.
  - CSR accesses complete in the first access-phase cycle: pready=1, zero wait.
- Flash-window write: pready=1 and pslverr=1 in the first access-phase cycle; no SPI activity.
- Flash read: address aligned to 4 (paddr[1:0] dropped).
- FSM states: IDLE -> CS_SETUP (1 cycle, selected cs low) -> SHIFT (NBITS = 8+8*ADDR_BYTES+32 bits) -> CS_HOLD (1 cycle, cs high, pready=1) -> IDLE.
- Bit timing: each SPI half-period lasts DIV+1 clk cycles.
  - mosi updates while spi_clk is low; miso is sampled on the rising edge.
  - MSB-first order: opcode 0x03, then address MSB-first, then 32 data bits.
- Latency: first access-phase cycle to pready = 2 + NBITS*2*(DIV+1). DIV=0, ADDR_BYTES=3 gives 130.
- Data packing: the byte at the lowest address goes in prdata[7:0], the next in [15:8], and so on (little-endian word).
- in_prdata is valid only while pready=1; otherwise 0.
- pready is a single-cycle pulse. The next transfer cannot start before the following setup phase.
- DIV and CS_SEL are sampled at CS_SETUP. CSR writes are impossible mid-transfer because APB is blocked.
- psel dropped mid-transfer (protocol violation): the SPI transaction runs to completion and its result is discarded.
- Reset mid-transfer: immediate return to the reset state; cs deasserts asynchronously.

Optional Feature:
- Macro SPI_FLASH_XIP_LINEBUF_EN.
- Defined: one-word read buffer holding {valid, word address, data}.
  - A flash read matching the buffered address completes in its first access-phase cycle with the buffered data and no SPI activity.
  - The buffer fills on every completed SPI read.
  - valid clears on reset and on any CSR write.
- Undefined: every flash read goes to SPI; no buffer logic.

Decomposition:
- Package spi_flash_xip_pkg holds:
  - FSM state encoding (IDLE, CS_SETUP, SHIFT, CS_HOLD);
  - CSR offsets (0x00, 0x04, 0x08);
  - READ opcode 0x03;
  - NBITS function of ADDR_BYTES.
- One sub-module, spi_flash_xip_shifter, contains:
  - the divider counter;
  - the sclk toggle;
  - the bit counter;
  - the 64/72-bit TX/RX shift registers;
  - start/done handshake.
- The top holds the APB decode, CSRs, the FSM and the optional line buffer.

Test Plan:
- Reset check: assert reset mid-SHIFT. spi_cs=2'b11, spi_clk=0 and pready=0 immediately; read DIV -> 0 and CS_SEL -> 0.
- Single read, DIV=0: read 0x30000004, with the flash model returning bytes 11 22 33 44.
  - mosi carries 03 00 00 04; spi_cs=2'b10.
  - pready arrives 130 cycles after the access phase, prdata=0x44332211.
- Divider and CS: write DIV=3 and CS_SEL=1, then read 0x30000100.
  - spi_cs=2'b01; spi_clk period is 8 clk.
  - Latency is 514.
  - CS_SEL=2 write -> pslverr=1 and the value is unchanged.
- Errors: write to 0x30000000 -> pready=1 and pslverr=1 in the first access cycle, spi_cs stays high.
  - Read of CSR 0x08 while idle -> 0.
- Unaligned read of 0x30000006 -> address bytes sent are 00 00 04.
- With SPI_FLASH_XIP_LINEBUF_EN: two reads of 0x30000004.
  - The second completes in 1 cycle with the same data and no spi_clk toggles.
  - A CSR write followed by the same read re-triggers SPI.
